serial_cfg_master: RTL

Upstream configuration serializer for the analog backend sequencer. It accepts one parallel gain word from the host-side register logic over a valid/ready handshake. It then shifts the word out MSB-first on a slow serial clock/data pair (o_sclk/o_sdin). The backend samples o_sdin on each rising o_sclk edge, detected in the i_clk domain. The whole block runs on i_clk; o_sclk is a registered, divided strobe and is never used as a clock.

---
 rtl/cfg_pkg.sv | 19 +
 rtl/sclk_phase_timer.sv | 37 +++
 rtl/serial_cfg_master.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Definitions shared between the config serializer and the backend sequencer:
// the word width, the gain field layout and the serializer state encoding.
package cfg_pkg;

    localparam int CFG_W      = 5;

    localparam int GAINA1_LSB = 0;
    localparam int GAINA1_W   = 3;
    localparam int GAINA2_LSB = 3;
    localparam int GAINA2_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/sclk_phase_timer.sv
// Half-period timer for the serial clock. It counts up from zero and flags the
// last cycle of a HALF_PER-cycle phase. Clearing restarts the phase.
module sclk_phase_timer #(
    parameter int HALF_PER = 4
) (
    input  logic i_clk,
    input  logic i_resetbAll,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CNT_W = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HALF_PER - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear, otherwise advance (free wrap, no saturation).
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    // Phase counter register.
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/serial_cfg_master.sv
// Serializes one configuration word MSB-first onto a slow sclk/sdin pair.
// Both serial outputs are registered strobes in the i_clk domain.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a new word, sclk/sdin low
//   SETUP | sclk low, current MSB presented on sdin for HALF_PER cycles
//   HIGH  | sclk high, sdin held for HALF_PER cycles
//   DONE  | one-cycle completion pulse, then back to IDLE
module serial_cfg_master
    import cfg_pkg::*;
#(
    parameter int DATA_W   = CFG_W,
    parameter int HALF_PER = 4
) (
    input  logic              i_clk,
    input  logic              i_resetbAll,
    input  logic [DATA_W-1:0] i_cfg_data,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    output logic              o_sclk,
    output logic              o_sdin,
    output logic              o_busy,
    output logic              o_done
);

    // A one-cycle level could be missed by the consumer's edge detector.
    if (HALF_PER < 2) begin : g_half_per_check
        $error("serial_cfg_master: HALF_PER=%0d is illegal, must be at least 2", HALF_PER);
    end

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    cfg_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic              sclk_q,  sclk_d;
    logic              sdin_q,  sdin_d;
    logic              done_q,  done_d;
    logic              ready_q, ready_d;
    logic              phase_tc;
    logic              phase_clr;

    // Each state entry starts a fresh half period.
    assign phase_clr = (state_d != state_q);

    sclk_phase_timer #(
        .HALF_PER (HALF_PER)
    ) u_phase_timer (
        .i_clk       (i_clk),
        .i_resetbAll (i_resetbAll),
        .clr_i       (phase_clr),
        .tc_o        (phase_tc)
    );

    // Next state, shifter and bit counter; outputs derive from the next state
    // so they can be registered without adding a cycle of latency.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (i_cfg_valid && ready_q) begin
                    shift_d = i_cfg_data;
                    bit_d   = BIT_LAST;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_tc) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_tc) begin
                    if (bit_q != '0) begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sclk_d  = (state_d == HIGH);
        sdin_d  = ((state_d == SETUP) || (state_d == HIGH)) ? shift_d[DATA_W-1] : 1'b0;
        done_d  = (state_d == DONE);
        ready_d = (state_d == IDLE);
    end

    // State, datapath and registered outputs; ready stays low through reset.
    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sdin_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sdin_q  <= sdin_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign o_cfg_ready = ready_q;
    assign o_sclk      = sclk_q;
    assign o_sdin      = sdin_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q != IDLE);

endmodule
